// File: rtl/spm_pkg.sv
// Shared types and helpers for the serial-parallel multiplier engine.
package spm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } spm_state_e;

    // Counter must reach N inclusive.
    function automatic int spm_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spm_cell.sv
// One bit cell of the carry-save chain; in neg mode it becomes a serial
// two's-complement negator (sticky flag held in the carry flop).
module spm_cell (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic neg,
    input  logic x,
    input  logic y,
    input  logic sin,
    output logic sum
);

    logic       sum_q, sum_d;
    logic       c_q, c_d;
    logic       a;
    logic [1:0] tot;

    assign a   = x & y;
    assign sum = sum_q;

    always_comb begin
        tot   = {1'b0, a} + {1'b0, sin} + {1'b0, c_q};
        sum_d = tot[0];
        c_d   = tot[1];
        if (neg) begin
            sum_d = a ^ c_q;
            c_d   = c_q | a;
        end
        if (clr) begin
            sum_d = 1'b0;
            c_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= 1'b0;
            c_q   <= 1'b0;
        end else begin
            sum_q <= sum_d;
            c_q   <= c_d;
        end
    end

endmodule

// File: rtl/spm_engine.sv
// Serial-parallel multiplier: y is fed LSB-first through an XW-cell
// carry-save chain and the serial product is collected into prod.
module spm_engine
    import spm_pkg::*;
#(
    parameter int XW = 32,
    parameter int YW = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               tc,
    input  logic [XW-1:0]      x,
    input  logic [YW-1:0]      y,
    output logic               busy,
    output logic               done,
    output logic [XW+YW-1:0]   prod
);

    localparam int N  = XW + YW;
    localparam int CW = spm_cnt_w(N);

    spm_state_e    state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          tc_q, tc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  sh_q, sh_d;
    logic [N-1:0]  prod_q, prod_d;
    logic          clr, run, ybit, p;
    logic [XW-1:0] s;

    assign ybit = run & y_q[0];
    assign p    = s[0];
    assign busy = (state_q == CLEAR) || (state_q == RUN);
    assign done = (state_q == DONE);
    assign prod = prod_q;

    for (genvar i = 0; i < XW; i++) begin : g_cell
        logic sin_i, neg_i;
        if (i == XW - 1) begin : g_top
            assign sin_i = 1'b0;
            assign neg_i = tc_q;
        end else begin : g_mid
            assign sin_i = s[i+1];
            assign neg_i = 1'b0;
        end
        spm_cell u_cell (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .neg (neg_i),
            .x   (x_q[i]),
            .y   (ybit),
            .sin (sin_i),
            .sum (s[i])
        );
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        tc_d    = tc_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        prod_d  = prod_q;
        clr     = 1'b0;
        run     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    x_d     = x;
                    y_d     = y;
                    tc_d    = tc;
                    state_d = CLEAR;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                clr     = 1'b1;
                sh_d    = '0;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                run   = 1'b1;
                // First capture is the cleared cell 0; it falls off the LSB end.
                sh_d  = {p, sh_q[N-1:1]};
                y_d   = {tc_q & y_q[YW-1], y_q[YW-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N)) begin
                    prod_d  = sh_d;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            tc_q    <= 1'b0;
            cnt_q   <= '0;
            sh_q    <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            tc_q    <= tc_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            prod_q  <= prod_d;
        end
    end

endmodule
